// File: rtl/anton_product_pkg.sv
// Shared constants for the anton_product transaction sequencer:
// FSM state encodings, nibble index map and parameter defaults.
package anton_product_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE  = 3'd0;
   localparam state_t ST_CLEAR = 3'd1;
   localparam state_t ST_LOAD  = 3'd2;
   localparam state_t ST_WAIT  = 3'd3;
   localparam state_t ST_DONE  = 3'd4;

   localparam int unsigned NIBBLES_PER_TXN = 4;

   // Order in which the core expects operand nibbles under the read strobe
   localparam logic [1:0] IDX_A_LO = 2'd0;
   localparam logic [1:0] IDX_A_HI = 2'd1;
   localparam logic [1:0] IDX_B_LO = 2'd2;
   localparam logic [1:0] IDX_B_HI = 2'd3;

   localparam int unsigned DEF_CLEAR_CYCLES = 1;
   localparam int unsigned DEF_RESULT_WAIT  = 2;

endpackage

// File: rtl/anton_product_nibble_mux.sv
// Selects one operand nibble for the core by load index.
module anton_product_nibble_mux
   import anton_product_pkg::*;
(
   input  logic [1:0] idx,
   input  logic [7:0] a,
   input  logic [7:0] b,
   output logic [3:0] nibble
);

   always_comb begin
      nibble = '0;
      case (idx)
         IDX_A_LO: nibble = a[3:0];
         IDX_A_HI: nibble = a[7:4];
         IDX_B_LO: nibble = b[3:0];
         IDX_B_HI: nibble = b[7:4];
         default:  nibble = '0;
      endcase
   end

endmodule

// File: rtl/anton_product_seq.sv
// Sequencer for the anton_product nibble-serial multiplier: clears the core,
// streams four operand nibbles, waits a settle time and returns the product.
module anton_product_seq
   import anton_product_pkg::*;
#(
   parameter int unsigned CLEAR_CYCLES = DEF_CLEAR_CYCLES,
   parameter int unsigned RESULT_WAIT  = DEF_RESULT_WAIT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] op_a,
   input  logic [7:0] op_b,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] result,
   output logic       busy,
   output logic       core_reset,
   output logic       core_read,
   output logic [3:0] core_nibble,
   input  logic [7:0] core_result
);

   state_t     state;
   logic [3:0] cnt;
   logic [7:0] a_q;
   logic [7:0] b_q;
   logic [3:0] mux_nibble;

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         a_q    <= '0;
         b_q    <= '0;
         result <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  a_q   <= op_a;
                  b_q   <= op_b;
                  cnt   <= '0;
                  state <= ST_CLEAR;
               end
            end
            ST_CLEAR: begin
               if (cnt == 4'(CLEAR_CYCLES - 1)) begin
                  cnt   <= '0;
                  state <= ST_LOAD;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            ST_LOAD: begin
               if (cnt == 4'(NIBBLES_PER_TXN - 1)) begin
                  cnt   <= '0;
                  state <= ST_WAIT;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            ST_WAIT: begin
               // Core output is only trusted after the full settle window
               if (cnt == 4'(RESULT_WAIT - 1)) begin
                  result <= core_result;
                  cnt    <= '0;
                  state  <= ST_DONE;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            ST_DONE: begin
               if (out_ready) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   anton_product_nibble_mux u_mux (
      .idx    (cnt[1:0]),
      .a      (a_q),
      .b      (b_q),
      .nibble (mux_nibble)
   );

   // Reset overrides the handshake and core strobes within the same cycle
   assign in_ready    = (state == ST_IDLE) & ~reset;
   assign out_valid   = (state == ST_DONE) & ~reset;
   assign busy        = (state != ST_IDLE) & ~reset;
   assign core_reset  = reset | (state == ST_CLEAR);
   assign core_read   = (state == ST_LOAD) & ~reset;
   assign core_nibble = core_read ? mux_nibble : 4'h0;

endmodule

// File: tb/tb_anton_product_seq.sv
// Bench for anton_product_seq with a behavioural nibble-serial core model.
module tb_anton_product_seq;

   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid, in_ready, out_valid, out_ready, busy;
   logic       core_reset, core_read;
   logic [7:0] op_a, op_b, result, core_result;
   logic [3:0] core_nibble;

   logic       iv2, ir2, ov2, or2, busy2, crst2, crd2;
   logic [7:0] a2, b2, res2, cres2;
   logic [3:0] cnib2;

   int         cyc = 0;
   int         nchk = 0;
   int         nerr = 0;
   int         acc_last = 0;
   logic [7:0] sb[$];

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] exp;
   } vec_t;
   vec_t tbl[6];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   anton_product_seq dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .op_a(op_a), .op_b(op_b), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .busy(busy), .core_reset(core_reset),
      .core_read(core_read), .core_nibble(core_nibble), .core_result(core_result)
   );

   anton_product_seq #(.CLEAR_CYCLES(3), .RESULT_WAIT(1)) dut2 (
      .clk(clk), .reset(reset), .in_valid(iv2), .in_ready(ir2),
      .op_a(a2), .op_b(b2), .out_valid(ov2), .out_ready(or2),
      .result(res2), .busy(busy2), .core_reset(crst2),
      .core_read(crd2), .core_nibble(cnib2), .core_result(cres2)
   );

   // Core model: nibbles shift in a_lo first, product of the two bytes
   logic [15:0] sh1, sh2;
   always_ff @(posedge clk) begin
      if (core_reset) sh1 <= '0;
      else if (core_read) sh1 <= {core_nibble, sh1[15:4]};
      if (crst2) sh2 <= '0;
      else if (crd2) sh2 <= {cnib2, sh2[15:4]};
   end
   assign core_result = sh1[7:0] * sh1[15:8];
   assign cres2       = sh2[7:0] * sh2[15:8];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard consumer and strobe sanity
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         if (sb.size() == 0) chk("sb_empty", 1, 0);
         else chk("result", result, sb.pop_front());
      end
      if (core_read) chk("read_outside_txn", busy, 1);
   end

   // Offers a pair and returns just after the accepting edge, in_valid still high
   task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [7:0] exp,
                       output int acc);
      bit ok = 0;
      in_valid = 1'b1;
      op_a = a;
      op_b = b;
      acc = -1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1;
            break;
         end
         tick();
      end
      if (!ok) chk("accept_timeout", 0, 1);
      else begin
         acc = cyc;
         acc_last = cyc;
         sb.push_back(exp);
         tick();
      end
   endtask

   // Returns at the falling edge of the first out_valid cycle
   task automatic wait_ov(output int lat);
      bit ok = 0;
      lat = -1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (out_valid) begin
            ok = 1;
            lat = cyc - acc_last;
            break;
         end
         tick();
      end
      if (!ok) chk("out_valid_timeout", 0, 1);
   endtask

   task automatic drain();
      bit ok = 0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (sb.size() == 0 && !busy) begin
            ok = 1;
            break;
         end
         tick();
      end
      if (!ok) chk("drain_timeout", 0, 1);
      tick();
   endtask

   initial begin
      int acc, lat, hs;
      int accs[6];
      logic [5:0] strb_exp[10];

      tbl[0] = '{8'h03, 8'h05, 8'h0F};
      tbl[1] = '{8'h10, 8'h0F, 8'hF0};
      tbl[2] = '{8'hFF, 8'hFF, 8'h01};
      tbl[3] = '{8'h12, 8'h11, 8'h32};
      tbl[4] = '{8'h00, 8'hA5, 8'h00};
      tbl[5] = '{8'h0E, 8'h0D, 8'hB6};

      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op_a = '0; op_b = '0;
      iv2 = 1'b0; or2 = 1'b0; a2 = '0; b2 = '0;
      tick(); tick();
      @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_core_reset", core_reset, 1);
      chk("rst_outs", {out_valid, busy, core_read, core_nibble, result}, 0);
      tick();
      reset = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", in_ready, 1);
      chk("post_rst_core_reset", core_reset, 0);
      tick();

      // Nibble order: {core_reset, core_read, core_nibble} per cycle after accept
      out_ready = 1'b1;
      strb_exp[1] = 6'b10_0000; strb_exp[2] = 6'b01_0111; strb_exp[3] = 6'b01_1010;
      strb_exp[4] = 6'b01_1100; strb_exp[5] = 6'b01_0011; strb_exp[6] = 6'b00_0000;
      strb_exp[7] = 6'b00_0000;
      send(8'hA7, 8'h3C, 8'h24, acc);
      in_valid = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         chk($sformatf("strobe_c%0d", k), {core_reset, core_read, core_nibble}, strb_exp[k]);
         tick();
      end
      @(negedge clk);
      chk("nib_ov_c8", out_valid, 1);
      tick();
      @(negedge clk);
      chk("nib_idle_c9", {busy, in_ready}, 2'b01);
      tick();

      // End-to-end product and latency
      send(tbl[0].a, tbl[0].b, tbl[0].exp, acc);
      in_valid = 1'b0;
      wait_ov(lat);
      chk("latency", lat, 8);
      tick();
      @(negedge clk);
      chk("e2e_idle", {busy, in_ready}, 2'b01);
      tick();

      // Backpressure with a new pair offered throughout
      out_ready = 1'b0;
      send(8'h11, 8'h12, 8'h32, acc);
      op_a = 8'h0E; op_b = 8'h0D;
      wait_ov(lat);
      tick();
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk("bp_hold", {out_valid, in_ready, core_read, result}, {3'b100, 8'h32});
         tick();
      end
      out_ready = 1'b1;
      @(negedge clk);
      hs = cyc;
      tick();
      send(8'h0E, 8'h0D, 8'hB6, acc);
      in_valid = 1'b0;
      chk("bp_next_accept", acc - hs, 1);
      drain();

      // Reset on the second LOAD cycle
      send(8'hA7, 8'h3C, 8'h24, acc);
      in_valid = 1'b0;
      tick(); tick();
      reset = 1'b1;
      @(negedge clk);
      chk("midrst_core", {core_reset, core_read}, 2'b10);
      tick();
      reset = 1'b0;
      sb.delete();
      @(negedge clk);
      chk("midrst_after", {busy, out_valid, in_ready, result}, {3'b001, 8'h00});
      tick();
      send(8'hFF, 8'hFF, 8'h01, acc);
      in_valid = 1'b0;
      drain();

      // Back-to-back from the vector table
      for (int i = 0; i < 6; i++) send(tbl[i].a, tbl[i].b, tbl[i].exp, accs[i]);
      in_valid = 1'b0;
      for (int i = 1; i < 6; i++) chk($sformatf("b2b_space_%0d", i), accs[i] - accs[i-1], 9);
      drain();

      // Parameter sweep on the CLEAR_CYCLES=3, RESULT_WAIT=1 instance
      iv2 = 1'b1; a2 = 8'h03; b2 = 8'h05; or2 = 1'b1;
      @(negedge clk);
      chk("sw_accept", ir2, 1);
      tick();
      iv2 = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         @(negedge clk);
         chk($sformatf("sw_c%0d", k), {crst2, ov2}, {(k <= 3), (k == 9)});
         if (k == 9) chk("sw_result", res2, 8'h0F);
         tick();
      end
      @(negedge clk);
      chk("sw_idle", {busy2, ir2}, 2'b01);
      chk("sb_leftover", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule

// File: doc/anton_product_seq.md
Name: anton_product_seq

Overview:
- Transaction sequencer in front of the anton_product nibble-serial multiplier core.
- Accepts a pair of 8-bit operands through a valid/ready handshake.
- Clears the core, streams the four operand nibbles under the read strobe, and waits a fixed settle time.
- Captures the core's 8-bit output and presents it through a valid/ready result handshake.
- Instantiated next to the core in the top level; drives the core's reset/read/nibble inputs in place of the external pins.

Parameters:
- CLEAR_CYCLES, 1, cycles core_reset is held high at the start of each transaction (legal range 1..15).
- RESULT_WAIT, 2, cycles between the last nibble strobe and result capture (legal range 1..15).

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operand pair offered
- in_ready  out  1  sequencer can accept an operand pair
- op_a  in  8  first operand
- op_b  in  8  second operand
- out_valid  out  1  result held and valid
- out_ready  in  1  consumer accepts result
- result  out  8  captured core output
- busy  out  1  high in any state other than IDLE
- core_reset  out  1  to core reset input
- core_read  out  1  to core read input
- core_nibble  out  4  to core nibble input
- core_result  in  8  from core outputs

Behaviour:
- Reset (sync, active-high):
  - state=IDLE; in_ready=0 during the reset cycle, 1 from the first cycle after reset deasserts.
  - out_valid=0, result=8'h00, busy=0, core_read=0, core_nibble=0.
  - core_reset=1 combinationally whenever reset=1 (core_reset = reset | (state==CLEAR)).
- States: IDLE, CLEAR, LOAD, WAIT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch op_a/op_b into internal regs, go to CLEAR, counter=0.
- CLEAR:
  - core_reset=1 for exactly CLEAR_CYCLES cycles, then LOAD with index=0.
- LOAD: exactly 4 cycles with core_read=1.
  - core_nibble order: idx0=a[3:0], idx1=a[7:4], idx2=b[3:0], idx3=b[7:4].
  - After idx3, go to WAIT with counter=0.
- WAIT:
  - core_read=0, core_nibble=0 for exactly RESULT_WAIT cycles.
  - On the edge ending the last WAIT cycle, result<=core_result; go to DONE.
- DONE:
  - out_valid=1; result stable until handshake.
  - On out_ready: out_valid drops next cycle, state goes to IDLE.
  - out_ready may already be high on the first DONE cycle (single-cycle DONE).
- core_read and core_nibble are 0 in every state except LOAD.
- in_ready is 0 in every state except IDLE. in_valid while busy is ignored; the operand registers do not change.
- Latency: the accept edge ends cycle 0; out_valid first high in cycle 1+CLEAR_CYCLES+4+RESULT_WAIT (cycle 8 at defaults).
- Throughput: the next accept is possible the cycle after the DONE handshake. No overlap between transactions.
- Reset mid-transaction (any state): abort immediately and return to IDLE.
  - The partial result is discarded; result returns to 8'h00.
  - The core is held in reset via core_reset for the duration of reset.
- Counters are 4-bit and never wrap within a transaction, given the legal parameter ranges.

Decomposition:
- Package anton_product_pkg:
  - state enum (IDLE, CLEAR, LOAD, WAIT, DONE)
  - NIBBLES_PER_TXN=4
  - nibble index constants
  - default CLEAR_CYCLES/RESULT_WAIT values
- One sub-module: anton_product_nibble_mux (2-bit index + op_a/op_b -> 4-bit nibble, combinational).
- The FSM and counters stay in anton_product_seq.
- The top-level wrapper instantiates anton_product_seq and the core; the bench instantiates them together.

Test Plan:
- Nibble order:
  - Stimulus: accept a=8'hA7, b=8'h3C.
  - Required: core_read high for cycles 2..5 after accept; core_nibble = 4'h7, 4'hA, 4'hC, 4'h3 in order; core_reset high in cycle 1 only.
- End-to-end product:
  - Stimulus: a=8'h03, b=8'h05, out_ready=1.
  - Required: out_valid in cycle 8 with result equal to the core model output (8'h0F); busy low and in_ready high in cycle 9.
- Backpressure:
  - Stimulus: out_ready=0 for 10 cycles after out_valid rises, with in_valid=1 and a different operand pair on op_a/op_b throughout.
  - Required: result unchanged, in_ready=0, no core_read pulses; after out_ready=1, IDLE and the new pair accepted on the following cycle.
- Reset mid-LOAD:
  - Stimulus: assert reset on the 2nd LOAD cycle for 1 cycle.
  - Required: core_reset=1 and core_read=0 that cycle; next cycle state=IDLE, out_valid=0, result=8'h00, in_ready=1; a subsequent transaction produces the correct result.
- Back-to-back transactions:
  - Stimulus: 3 pairs offered continuously, out_ready=1.
  - Required: accepts spaced 9 cycles apart at defaults; each result matches its pair; no nibble leaks between transactions.
- Parameter sweep:
  - Stimulus: CLEAR_CYCLES=3, RESULT_WAIT=1.
  - Required: core_reset high for 3 cycles; out_valid first high in cycle 9 after accept.
